alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters and
// registers the ALU result into a single-entry response slot.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid / reqN_ready       requester N handshake (N = 0, 1)
//   reqN_src_a/src_b/alu_op       requester N operands and opcode
//   alu_src_a/alu_src_b/alu_op    operands driven to the shared ALU
//   alu_result, alu_zero          same-cycle ALU outputs
//   rsp_valid / rsp_ready         response handshake
//   rsp_id, rsp_result, rsp_zero  owner and captured ALU outputs
//
// FIXED_PRIO = 0 round-robins on ties, 1 makes requester 0 always win.
// A granted requester that cannot be accepted (response slot full) keeps
// the grant until it handshakes, so its operands are not swapped away.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src_a,
  input  logic [31:0] req0_src_b,
  input  logic [3:0]  req0_alu_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src_a,
  input  logic [31:0] req1_src_b,
  input  logic [3:0]  req1_alu_op,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero
);

  logic accept_en;
  logic grant;
  logic gnt_valid;
  logic hs;
  logic last_grant;
  logic lock;
  logic lock_id;

  // Slot can take a new result when empty or being drained this cycle.
  assign accept_en = !rsp_valid || rsp_ready;

  always_comb begin
    grant = 1'b0;
    if (lock)                         grant = lock_id;
    else if (req0_valid && req1_valid) grant = FIXED_PRIO ? 1'b0 : ~last_grant;
    else if (req1_valid)              grant = 1'b1;
  end

  assign gnt_valid = grant ? req1_valid : req0_valid;

  // Readies are forced low while reset is held.
  assign req0_ready = !rst && accept_en && !grant && req0_valid;
  assign req1_ready = !rst && accept_en &&  grant && req1_valid;
  assign hs         = req0_ready || req1_ready;

  always_comb begin
    alu_src_a = 32'd0;
    alu_src_b = 32'd0;
    alu_op    = 4'b0000;
    if (gnt_valid) begin
      alu_src_a = grant ? req1_src_a  : req0_src_a;
      alu_src_b = grant ? req1_src_b  : req0_src_b;
      alu_op    = grant ? req1_alu_op : req0_alu_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      last_grant <= 1'b1;  // requester 0 wins the first tie
      lock       <= 1'b0;
      lock_id    <= 1'b0;
    end else if (hs) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      last_grant <= grant;
      lock       <= 1'b0;
    end else begin
      if (rsp_ready) rsp_valid <= 1'b0;
      // Granted but blocked: pin the grant on this requester.
      if (gnt_valid && !accept_en) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end
    end
  end

endmodule
